// File: rtl/led_palette_arbiter.sv
// -----------------------------------------------------------------------------
// led_palette_arbiter
//
// Purpose: drives a 4-LED RGB palette that normally mirrors a background
// palette. Two requesters can temporarily override a single LED lane with
// their own colour for a number of hold-timer ticks. Access is arbitrated
// round-robin; the winner owns the palette until its hold expires or it is
// aborted.
//
// Handshake: i_req is a level request per requester. It is only looked at
// while the arbiter is idle; the chosen requester sees a one-cycle o_grant
// pulse, and a one-cycle o_done pulse when its override ends. A requester
// that keeps i_req high after o_done is simply arbitrated again.
//
// Ports:
//   i_clk, i_rstn                  clock (rising edge), async active-low reset
//   i_bg_{red,green,blue}_value    background palette, LED n in [8n+7:8n]
//   i_req[1:0]                     level requests, bit k = requester k
//   i_reqK_led_index / _rgb /      override target lane, colour {R,G,B}
//   _hold_ticks                    and duration in ticks (0 acts as 1)
//   i_abort                        ends an active hold early
//   o_color_led_*_value            registered arbitrated palette
//   o_grant[1:0], o_done[1:0]      one-hot one-cycle pulses
//   o_busy                         high in GRANT, HOLD and RELEASE
// -----------------------------------------------------------------------------
module led_palette_arbiter #(
    parameter int unsigned parm_FCLK             = 40_000_000,
    parameter int unsigned parm_ticks_per_second = 128
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [31:0] i_bg_red_value,
    input  logic [31:0] i_bg_green_value,
    input  logic [31:0] i_bg_blue_value,
    input  logic [1:0]  i_req,
    input  logic [1:0]  i_req0_led_index,
    input  logic [1:0]  i_req1_led_index,
    input  logic [23:0] i_req0_rgb,
    input  logic [23:0] i_req1_rgb,
    input  logic [7:0]  i_req0_hold_ticks,
    input  logic [7:0]  i_req1_hold_ticks,
    input  logic        i_abort,
    output logic [31:0] o_color_led_red_value,
    output logic [31:0] o_color_led_green_value,
    output logic [31:0] o_color_led_blue_value,
    output logic [1:0]  o_grant,
    output logic [1:0]  o_done,
    output logic        o_busy
);

    localparam int unsigned DIV       = parm_FCLK / parm_ticks_per_second;
    localparam int unsigned CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_HOLD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // run_q rises on the first clock after reset release; the rest of the
    // design only advances once it is set, so the first active edge is the
    // second rising clock after i_rstn goes high.
    logic          run_q;
    state_t        state_q, state_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]    hold_cnt_q, hold_cnt_d;
    logic [1:0]    led_idx_q, led_idx_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          owner_q, owner_d;
    logic          last_served_q, last_served_d;
    logic [1:0]    grant_q, grant_d;
    logic [1:0]    done_q, done_d;
    logic [31:0]   red_q, red_d;
    logic [31:0]   green_q, green_d;
    logic [31:0]   blue_q, blue_d;

    logic          tick;
    logic          winner;
    logic [7:0]    sel_hold;

    assign tick = (tick_cnt_q == TICK_LAST);

    // Both requesting: the one not served last wins. Otherwise the single
    // requester wins (value irrelevant when nobody requests).
    always_comb begin
        if (i_req == 2'b11) begin
            winner = ~last_served_q;
        end else begin
            winner = i_req[1] & ~i_req[0];
        end
    end

    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;
        hold_cnt_d    = hold_cnt_q;
        led_idx_d     = led_idx_q;
        rgb_d         = rgb_q;
        owner_d       = owner_q;
        last_served_d = last_served_q;
        grant_d       = 2'b00;
        done_d        = 2'b00;
        sel_hold      = winner ? i_req1_hold_ticks : i_req0_hold_ticks;

        red_d   = i_bg_red_value;
        green_d = i_bg_green_value;
        blue_d  = i_bg_blue_value;
        if (state_q == S_HOLD) begin
            red_d[{led_idx_q, 3'b000} +: 8]   = rgb_q[23:16];
            green_d[{led_idx_q, 3'b000} +: 8] = rgb_q[15:8];
            blue_d[{led_idx_q, 3'b000} +: 8]  = rgb_q[7:0];
        end

        case (state_q)
            S_IDLE: begin
                if (i_req != 2'b00) begin
                    state_d    = S_GRANT;
                    owner_d    = winner;
                    led_idx_d  = winner ? i_req1_led_index : i_req0_led_index;
                    rgb_d      = winner ? i_req1_rgb : i_req0_rgb;
                    hold_cnt_d = (sel_hold == 8'd0) ? 8'd1 : sel_hold;
                    grant_d    = winner ? 2'b10 : 2'b01;
                end
            end
            S_GRANT: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (i_abort || (tick && hold_cnt_q == 8'd1)) begin
                    state_d = S_RELEASE;
                    done_d  = owner_q ? 2'b10 : 2'b01;
                end else if (tick) begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
            S_RELEASE: begin
                state_d       = S_IDLE;
                last_served_d = owner_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            run_q         <= 1'b0;
            state_q       <= S_IDLE;
            tick_cnt_q    <= '0;
            hold_cnt_q    <= 8'd0;
            led_idx_q     <= 2'd0;
            rgb_q         <= 24'd0;
            owner_q       <= 1'b0;
            last_served_q <= 1'b1;
            grant_q       <= 2'b00;
            done_q        <= 2'b00;
            red_q         <= 32'd0;
            green_q       <= 32'd0;
            blue_q        <= 32'd0;
        end else begin
            run_q <= 1'b1;
            if (run_q) begin
                state_q       <= state_d;
                tick_cnt_q    <= tick_cnt_d;
                hold_cnt_q    <= hold_cnt_d;
                led_idx_q     <= led_idx_d;
                rgb_q         <= rgb_d;
                owner_q       <= owner_d;
                last_served_q <= last_served_d;
                grant_q       <= grant_d;
                done_q        <= done_d;
                red_q         <= red_d;
                green_q       <= green_d;
                blue_q        <= blue_d;
            end
        end
    end

    assign o_color_led_red_value   = red_q;
    assign o_color_led_green_value = green_q;
    assign o_color_led_blue_value  = blue_q;
    assign o_grant                 = grant_q;
    assign o_done                  = done_q;
    assign o_busy                  = (state_q != S_IDLE);

endmodule

// File: tb/tb_led_palette_arbiter.sv
// -----------------------------------------------------------------------------
// tb_led_palette_arbiter
//
// Bench for led_palette_arbiter with a 4-cycle tick (512 Hz clock, 128 ticks/s).
// The reference model works at transaction level: when a grant is predicted it
// computes the release edge directly from the tick period and hold length
// (shortened by an abort), and derives palette/grant/done/busy from where the
// current edge lies relative to that window.
// -----------------------------------------------------------------------------
module tb_led_palette_arbiter;

    localparam int DIV = 4;

    logic        clk;
    logic        rstn;
    logic [31:0] bg_r, bg_g, bg_b;
    logic [1:0]  req;
    logic [1:0]  idx0, idx1;
    logic [23:0] rgb0, rgb1;
    logic [7:0]  hold0, hold1;
    logic        abort;
    logic [31:0] o_r, o_g, o_b;
    logic [1:0]  o_grant, o_done;
    logic        o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    led_palette_arbiter #(
        .parm_FCLK            (512),
        .parm_ticks_per_second(128)
    ) dut (
        .i_clk                  (clk),
        .i_rstn                 (rstn),
        .i_bg_red_value         (bg_r),
        .i_bg_green_value       (bg_g),
        .i_bg_blue_value        (bg_b),
        .i_req                  (req),
        .i_req0_led_index       (idx0),
        .i_req1_led_index       (idx1),
        .i_req0_rgb             (rgb0),
        .i_req1_rgb             (rgb1),
        .i_req0_hold_ticks      (hold0),
        .i_req1_hold_ticks      (hold1),
        .i_abort                (abort),
        .o_color_led_red_value  (o_r),
        .o_color_led_green_value(o_g),
        .o_color_led_blue_value (o_b),
        .o_grant                (o_grant),
        .o_done                 (o_done),
        .o_busy                 (o_busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          edge_n;
    int          k;
    logic        m_active;
    int          m_owner;
    int          m_last;
    int          g_edge;
    int          r_edge;
    logic [1:0]  m_idx;
    logic [23:0] m_rgb;
    logic [31:0] exp_r, exp_g, exp_b;
    logic [1:0]  exp_grant, exp_done;
    logic        exp_busy;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            edge_n    = 0;
            m_active  = 1'b0;
            m_owner   = 0;
            m_last    = 1;
            g_edge    = 0;
            r_edge    = 0;
            m_idx     = 2'd0;
            m_rgb     = 24'd0;
            exp_r     = 32'd0;
            exp_g     = 32'd0;
            exp_b     = 32'd0;
            exp_grant = 2'b00;
            exp_done  = 2'b00;
            exp_busy  = 1'b0;
        end else begin
            edge_n = edge_n + 1;
            k      = edge_n - 1;
            if (k >= 1) begin
                automatic logic in_hold = m_active && (k >= g_edge + 2) && (k <= r_edge);
                automatic int   lane    = int'(m_idx) * 8;
                if (in_hold && abort) r_edge = k;
                exp_r = bg_r;
                exp_g = bg_g;
                exp_b = bg_b;
                if (in_hold) begin
                    exp_r[lane +: 8] = m_rgb[23:16];
                    exp_g[lane +: 8] = m_rgb[15:8];
                    exp_b[lane +: 8] = m_rgb[7:0];
                end
                exp_grant = 2'b00;
                exp_done  = 2'b00;
                if (m_active && k == r_edge) begin
                    exp_done = (m_owner == 1) ? 2'b10 : 2'b01;
                end else if (m_active && k == r_edge + 1) begin
                    m_last   = m_owner;
                    m_active = 1'b0;
                end else if (!m_active && req != 2'b00) begin
                    automatic int w;
                    automatic int h;
                    automatic int first_tick;
                    if (req == 2'b11) w = (m_last == 0) ? 1 : 0;
                    else              w = req[0] ? 0 : 1;
                    m_owner    = w;
                    m_idx      = (w == 1) ? idx1 : idx0;
                    m_rgb      = (w == 1) ? rgb1 : rgb0;
                    h          = (w == 1) ? int'(hold1) : int'(hold0);
                    if (h == 0) h = 1;
                    g_edge     = k;
                    first_tick = ((k + 2 + DIV - 1) / DIV) * DIV;
                    r_edge     = first_tick + (h - 1) * DIV;
                    exp_grant  = (w == 1) ? 2'b10 : 2'b01;
                    m_active   = 1'b1;
                end
                exp_busy = m_active;
            end
        end
    end

    wire [100:0] obs_vec = {o_r, o_g, o_b, o_grant, o_done, o_busy};
    wire [100:0] exp_vec = {exp_r, exp_g, exp_b, exp_grant, exp_done, exp_busy};

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        req   = 2'b00;
        abort = 1'b0;
        idx0  = 2'd0;
        idx1  = 2'd0;
        rgb0  = 24'd0;
        rgb1  = 24'd0;
        hold0 = 8'd0;
        hold1 = 8'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstn = 1'b1;
        drive_idle();
        bg_r = 32'hA1A2_A3A4;
        bg_g = 32'hB1B2_B3B4;
        bg_b = 32'hC1C2_C3C4;
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (obs_vec !== 101'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", obs_vec);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_r !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_sync_first_edge: red got %h want 0", o_r);
        end
        @(negedge clk);
        n_checks++;
        if ({o_r, o_g, o_b} !== {32'hA1A2_A3A4, 32'hB1B2_B3B4, 32'hC1C2_C3C4}) begin
            n_fail++;
            $display("FAIL reset_bg_pass: got %h %h %h", o_r, o_g, o_b);
        end
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_model: got %h want %h", obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_single();
        int grants = 0, dones = 0, ovr = 0;
        bg_r = 32'h1100_3344;
        bg_g = 32'h5566_7788;
        bg_b = 32'h99AA_BBCC;
        @(negedge clk);
        req  = 2'b01;
        idx0 = 2'd2;
        rgb0 = 24'hFF0000;
        hold0 = 8'd3;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL single_model c=%0d: got %h want %h", c, obs_vec, exp_vec);
            end
            if (c == 0) begin
                n_checks++;
                if (o_grant !== 2'b01) begin
                    n_fail++;
                    $display("FAIL single_grant_latency: got %b want 01", o_grant);
                end
            end
            if (o_grant == 2'b01) begin
                grants++;
                req = 2'b00;
            end
            if (o_done == 2'b01) dones++;
            if (o_r[23:16] == 8'hFF && o_g[23:16] == 8'h00 && o_b[23:16] == 8'h00) ovr++;
        end
        n_checks++;
        if (grants != 1 || dones != 1) begin
            n_fail++;
            $display("FAIL single_pulses: grants=%0d dones=%0d want 1/1", grants, dones);
        end
        n_checks++;
        if (ovr < 2 * DIV + 1 || ovr > 3 * DIV) begin
            n_fail++;
            $display("FAIL single_hold_len: got %0d cycles want %0d..%0d", ovr, 2 * DIV + 1, 3 * DIV);
        end
        n_checks++;
        if ({o_r, o_g, o_b} !== {32'h1100_3344, 32'h5566_7788, 32'h99AA_BBCC}) begin
            n_fail++;
            $display("FAIL single_bg_return: got %h %h %h", o_r, o_g, o_b);
        end
    endtask

    task automatic test_contention();
        logic [2:0] exp_q[$];
        logic [2:0] got_q[$];
        int n_grants = 0;
        do_reset();
        bg_r = $urandom;
        bg_g = $urandom;
        bg_b = $urandom;
        req   = 2'b11;
        idx0  = 2'd1;
        idx1  = 2'd3;
        rgb0  = 24'h102030;
        rgb1  = 24'h405060;
        hold0 = 8'd1;
        hold1 = 8'd1;
        exp_q = '{3'b001, 3'b101, 3'b010, 3'b110, 3'b001, 3'b101};
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL contention_model c=%0d: got %h want %h", c, obs_vec, exp_vec);
            end
            if (o_grant != 2'b00) begin
                got_q.push_back({1'b0, o_grant});
                n_grants++;
                if (n_grants == 3) req = 2'b00;
            end
            if (o_done != 2'b00) got_q.push_back({1'b1, o_done});
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL contention_count: got %0d events want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL contention_order[%0d]: got %b want %b", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_zero_hold();
        int dones = 0, ovr = 0;
        bg_r = 32'hAAAA_AAAA;
        bg_g = 32'hBBBB_BBBB;
        bg_b = 32'hCCCC_CCCC;
        @(negedge clk);
        req   = 2'b10;
        idx1  = 2'd1;
        rgb1  = 24'h123456;
        hold1 = 8'd0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL zero_hold_model c=%0d: got %h want %h", c, obs_vec, exp_vec);
            end
            if (o_grant != 2'b00) req = 2'b00;
            if (o_done == 2'b10) dones++;
            if (o_r[15:8] == 8'h12 && o_g[15:8] == 8'h34 && o_b[15:8] == 8'h56) ovr++;
        end
        n_checks++;
        if (dones != 1 || ovr < 1 || ovr > DIV) begin
            n_fail++;
            $display("FAIL zero_hold: dones=%0d ovr=%0d want 1 and 1..%0d", dones, ovr, DIV);
        end
    endtask

    task automatic test_abort();
        int c;
        logic seen;
        bg_r = 32'h0102_0304;
        bg_g = 32'h0506_0708;
        bg_b = 32'h090A_0B0C;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_grant !== 2'b00 || o_done !== 2'b00 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle_ignored: grant=%b done=%b busy=%b want 00/00/0", o_grant, o_done, o_busy);
        end
        abort = 1'b0;
        req   = 2'b01;
        idx0  = 2'd0;
        rgb0  = 24'hABCDEF;
        hold0 = 8'd50;
        seen  = 1'b0;
        for (c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (o_grant == 2'b01) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL abort_grant_timeout: got no grant want 01");
        end
        req = 2'b00;
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL abort_hold_model: got %h want %h", obs_vec, exp_vec);
            end
        end
        n_checks++;
        if (o_r[7:0] !== 8'hAB) begin
            n_fail++;
            $display("FAIL abort_override_active: red lane0 got %h want ab", o_r[7:0]);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (o_done !== 2'b01) begin
            n_fail++;
            $display("FAIL abort_done: got %b want 01", o_done);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({o_r[7:0], o_g[7:0], o_b[7:0], o_busy} !== {8'h04, 8'h08, 8'h0C, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_revert: got %h%h%h busy=%b want 04080c busy=0", o_r[7:0], o_g[7:0], o_b[7:0], o_busy);
        end
    endtask

    task automatic test_reset_mid_hold();
        int c;
        logic seen;
        int dones = 0;
        bg_r = $urandom;
        bg_g = $urandom;
        bg_b = $urandom;
        @(negedge clk);
        req   = 2'b11;
        hold0 = 8'd40;
        hold1 = 8'd40;
        idx0  = 2'd3;
        idx1  = 2'd2;
        rgb0  = 24'h111111;
        rgb1  = 24'h222222;
        seen  = 1'b0;
        for (c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (o_grant != 2'b00) seen = 1'b1;
        end
        n_checks++;
        if (o_grant !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_hold_first_grant: got %b want 10", o_grant);
        end
        req = 2'b00;
        repeat (5) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (obs_vec !== 101'd0) begin
            n_fail++;
            $display("FAIL rst_hold_outputs: got %h want 0", obs_vec);
        end
        repeat (3) begin
            @(negedge clk);
            if (o_done != 2'b00) dones++;
        end
        rstn = 1'b1;
        req  = 2'b11;
        seen = 1'b0;
        for (c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (o_done != 2'b00) dones++;
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL rst_hold_model c=%0d: got %h want %h", c, obs_vec, exp_vec);
            end
            if (o_grant != 2'b00) seen = 1'b1;
        end
        n_checks++;
        if (o_grant !== 2'b01 || dones != 0) begin
            n_fail++;
            $display("FAIL rst_hold_regrant: grant=%b dones=%0d want 01 and 0", o_grant, dones);
        end
        req = 2'b00;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random_model c=%0d: got %h want %h", c, obs_vec, exp_vec);
            end
            n_checks++;
            if ($countones(o_grant) > 1 || $countones(o_done) > 1 ||
                (o_grant != 2'b00 && o_done != 2'b00)) begin
                n_fail++;
                $display("FAIL random_pulse_excl c=%0d: grant=%b done=%b", c, o_grant, o_done);
            end
            bg_r  = $urandom;
            bg_g  = $urandom;
            bg_b  = $urandom;
            if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
            idx0  = 2'($urandom_range(0, 3));
            idx1  = 2'($urandom_range(0, 3));
            rgb0  = 24'($urandom);
            rgb1  = 24'($urandom);
            hold0 = 8'($urandom_range(0, 2));
            hold1 = 8'($urandom_range(0, 2));
            abort = ($urandom_range(0, 15) == 0);
        end
        drive_idle();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rstn = 1'b1;
        bg_r = 32'd0;
        bg_g = 32'd0;
        bg_b = 32'd0;
        drive_idle();
        test_reset();
        test_single();
        test_contention();
        test_zero_hold();
        test_abort();
        test_reset_mid_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_palette_arbiter.md
LED_PALETTE_ARBITER -- requirements
Module: led_palette_arbiter

Interface
REQ-001 SHALL have parameter parm_FCLK, default 40_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter parm_ticks_per_second, default 128, hold-timer tick rate; tick divisor DIV = parm_FCLK / parm_ticks_per_second.
REQ-003 SHALL have fixed LED count 4; each colour bus is 32 bits, LED n in bits [8n+7:8n].
REQ-004 SHALL have these ports:
- i_clk  in  1  sole clock, rising edge.
- i_rstn  in  1  reset, asynchronous assert, active-low.
- i_bg_red_value / i_bg_green_value / i_bg_blue_value  in  32 each  background palette.
- i_req  in  2  level request, bit k = requester k.
- i_req0_led_index / i_req1_led_index  in  2  target LED.
- i_req0_rgb / i_req1_rgb  in  24  override colour {R[23:16], G[15:8], B[7:0]}.
- i_req0_hold_ticks / i_req1_hold_ticks  in  8  override duration in ticks.
- i_abort  in  1  terminate active hold.
- o_color_led_red_value / o_color_led_green_value / o_color_led_blue_value  out  32 each  arbitrated palette.
- o_grant  out  2  one-cycle one-hot grant pulse.
- o_done  out  2  one-cycle one-hot completion pulse.
- o_busy  out  1  high in GRANT, HOLD, RELEASE.

Function
REQ-005 SHALL run a free-running tick counter 0..DIV-1 from reset; tick is high for one cycle when the count equals DIV-1, then the count wraps to 0.
REQ-006 SHALL implement FSM states IDLE, GRANT, HOLD, RELEASE; reset state IDLE.
REQ-007 IDLE: if any i_req bit is high, SHALL go to GRANT next cycle; otherwise stay in IDLE.
REQ-008 Arbitration SHALL be round-robin:
- Pointer last_served resets to 1, so requester 0 wins the first contention.
- With both requests high, the requester not equal to last_served wins.
- With one request high, that requester wins.
REQ-009 GRANT (one cycle) SHALL:
- Latch the winner's led_index, rgb and hold_ticks; a hold_ticks value of 0 is latched as 1.
- Pulse the winner's o_grant bit.
- Go to HOLD.
REQ-010 HOLD SHALL decrement the hold counter on each tick; when a tick occurs with counter == 1, go to RELEASE.
REQ-011 HOLD SHALL NOT be affected by i_req changes; request inputs are sampled only in IDLE.
REQ-012 i_abort high in HOLD SHALL force RELEASE next cycle regardless of tick; i_abort is ignored in IDLE, GRANT and RELEASE.
REQ-013 RELEASE (one cycle) SHALL:
- Pulse the owner's o_done bit.
- Set last_served to the owner.
- Go to IDLE.
REQ-014 A request still high in IDLE after RELEASE SHALL be re-arbitrated; with both requests high this alternates grants.
REQ-015 Palette outputs SHALL be registered with one-cycle latency from the i_bg_* inputs.
REQ-016 In HOLD, the latched LED lane SHALL be replaced by the latched rgb; all other lanes SHALL pass the background.
REQ-017 In IDLE, GRANT and RELEASE, all lanes SHALL pass the background.
REQ-018 o_grant and o_done SHALL never be high in the same cycle, and each SHALL have at most one bit set.
REQ-019 Minimum request-to-grant latency SHALL be 2 cycles: request sampled in IDLE, o_grant high in GRANT.

Reset
REQ-020 i_rstn low SHALL immediately and asynchronously clear state to IDLE and clear all outputs, the tick counter, the hold counter and the latched override.
REQ-021 Reset SHALL set last_served to 1.
REQ-022 Reset deassertion SHALL be synchronised internally; the first active edge occurs on the second rising i_clk after i_rstn rises.
REQ-023 Reset asserted during HOLD SHALL abandon the override with no o_done pulse.

Verification
REQ-024 DIV=4; i_req=01, idx=2, rgb=FF0000, hold=3 -> o_grant=01 two cycles later; LED2 lane = FF/00/00 for 3 ticks; o_done=01; then background returns.
REQ-025 i_req=11 held continuously from reset -> grants in order 01, 10, 01, with o_done between each pair.
REQ-026 hold_ticks=0 -> override lasts exactly 1 tick and o_done fires.
REQ-027 i_abort pulsed mid-HOLD -> RELEASE next cycle, o_done pulses, LED lane reverts to background.
REQ-028 i_rstn pulsed low mid-HOLD -> all outputs 0 immediately, no o_done; next i_req=11 grants requester 0.
